// File: rtl/rs_station_param_if.sv
// Dispatch / CDB / issue bundle for the parametrised reservation station.
// The master side is the dispatch, broadcast and unit context; the station is the slave.
interface rs_station_param_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned N_CDB  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
    logic                    rs_is_full;
    logic [CNT_W-1:0]        rs_count;

    logic                    dispatch_valid;
    logic [OP_W-1:0]         dispatch_op;
    logic [DATA_W-1:0]       dispatch_imm;
    logic [DATA_W-1:0]       dispatch_pc;
    logic                    dispatch_r1_valid;
    logic [DATA_W-1:0]       dispatch_r1_data;
    logic [TAG_W-1:0]        dispatch_r1_tag;
    logic                    dispatch_r2_valid;
    logic [DATA_W-1:0]       dispatch_r2_data;
    logic [TAG_W-1:0]        dispatch_r2_tag;
    logic [TAG_W-1:0]        dispatch_dest_tag;

    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data;

    logic                    issue_valid;
    logic                    issue_ready;
    logic [OP_W-1:0]         issue_op;
    logic [DATA_W-1:0]       issue_imm;
    logic [DATA_W-1:0]       issue_pc;
    logic [DATA_W-1:0]       issue_r1;
    logic [DATA_W-1:0]       issue_r2;
    logic [TAG_W-1:0]        issue_dest_tag;

    modport master (
        input  rs_is_full, rs_count,
        output dispatch_valid, dispatch_op, dispatch_imm, dispatch_pc,
        output dispatch_r1_valid, dispatch_r1_data, dispatch_r1_tag,
        output dispatch_r2_valid, dispatch_r2_data, dispatch_r2_tag, dispatch_dest_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  issue_valid, issue_op, issue_imm, issue_pc, issue_r1, issue_r2, issue_dest_tag,
        output issue_ready
    );

    modport slave (
        output rs_is_full, rs_count,
        input  dispatch_valid, dispatch_op, dispatch_imm, dispatch_pc,
        input  dispatch_r1_valid, dispatch_r1_data, dispatch_r1_tag,
        input  dispatch_r2_valid, dispatch_r2_data, dispatch_r2_tag, dispatch_dest_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output issue_valid, issue_op, issue_imm, issue_pc, issue_r1, issue_r2, issue_dest_tag,
        input  issue_ready
    );
endinterface

// File: rtl/rs_station_param.sv
// Parametrised reservation station: holds renamed instructions, wakes operands from
// N_CDB broadcast buses and issues the oldest ready entry over a valid/ready handshake.
module rs_station_param #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned N_CDB  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clear,
    rs_station_param_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned HIT_W = DATA_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              r1_valid;
        logic [DATA_W-1:0] r1_data;
        logic [TAG_W-1:0]  r1_tag;
        logic              r2_valid;
        logic [DATA_W-1:0] r2_data;
        logic [TAG_W-1:0]  r2_tag;
        logic [TAG_W-1:0]  dest_tag;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [TAG_W-1:0]  dest_tag;
    } issue_t;

    entry_t           ent   [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] older [DEPTH];   // older[i][j]: entry i was dispatched before entry j
    issue_t           iss;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] col;
    logic             sel_any;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             accept;
    logic [HIT_W-1:0] wk1 [DEPTH];
    logic [HIT_W-1:0] wk2 [DEPTH];
    logic [HIT_W-1:0] byp1;
    logic [HIT_W-1:0] byp2;
    entry_t           disp_ent;

    // {hit, data} of the lowest-numbered bus broadcasting tag
    function automatic logic [HIT_W-1:0] cdb_match(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        v,
        input logic [N_CDB*TAG_W-1:0]  t,
        input logic [N_CDB*DATA_W-1:0] d
    );
        logic [HIT_W-1:0] r;
        r = '0;
        for (int b = int'(N_CDB) - 1; b >= 0; b--) begin
            if (v[b] && (t[b*TAG_W +: TAG_W] == tag)) r = {1'b1, d[b*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    // Occupancy, lowest free slot and oldest ready entry, all from registered state
    always_comb begin
        ready      = '0;
        col        = '0;
        sel_any    = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        cnt        = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready[i] = ent_valid[i] && ent[i].r1_valid && ent[i].r2_valid;
            cnt      = cnt + CNT_W'(ent_valid[i]);
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int j = 0; j < int'(DEPTH); j++) col[j] = older[j][i];
            if (ready[i] && ((ready & col) == '0) && !sel_any) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Operand wakeup for stored entries and bypass for the dispatched one
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            wk1[i] = cdb_match(ent[i].r1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wk2[i] = cdb_match(ent[i].r2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        byp1 = cdb_match(bus.dispatch_r1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp2 = cdb_match(bus.dispatch_r2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        disp_ent.op       = bus.dispatch_op;
        disp_ent.imm      = bus.dispatch_imm;
        disp_ent.pc       = bus.dispatch_pc;
        disp_ent.r1_valid = bus.dispatch_r1_valid || byp1[DATA_W];
        disp_ent.r1_data  = bus.dispatch_r1_valid ? bus.dispatch_r1_data : byp1[DATA_W-1:0];
        disp_ent.r1_tag   = bus.dispatch_r1_tag;
        disp_ent.r2_valid = bus.dispatch_r2_valid || byp2[DATA_W];
        disp_ent.r2_data  = bus.dispatch_r2_valid ? bus.dispatch_r2_data : byp2[DATA_W-1:0];
        disp_ent.r2_tag   = bus.dispatch_r2_tag;
        disp_ent.dest_tag = bus.dispatch_dest_tag;
    end

    assign load   = (!iss.valid || bus.issue_ready) && sel_any;
    assign accept = bus.dispatch_valid && !bus.rs_is_full;

    // Entry valid bits, age matrix and issue register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) older[i] <= '0;
            iss <= '0;
        end else if (rdy) begin
            if (clear) begin
                ent_valid <= '0;
                for (int i = 0; i < int'(DEPTH); i++) older[i] <= '0;
                iss <= '0;
            end else begin
                if (load) begin
                    iss.valid          <= 1'b1;
                    iss.op             <= ent[sel_idx].op;
                    iss.imm            <= ent[sel_idx].imm;
                    iss.pc             <= ent[sel_idx].pc;
                    iss.r1             <= ent[sel_idx].r1_data;
                    iss.r2             <= ent[sel_idx].r2_data;
                    iss.dest_tag       <= ent[sel_idx].dest_tag;
                    ent_valid[sel_idx] <= 1'b0;
                end else if (bus.issue_ready) begin
                    iss.valid <= 1'b0;
                end
                if (accept) begin
                    ent_valid[free_idx] <= 1'b1;
                    older[free_idx]     <= '0;
                    for (int j = 0; j < int'(DEPTH); j++) older[j][free_idx] <= ent_valid[j];
                end
            end
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_valid[i]) begin
                    if (!ent[i].r1_valid && wk1[i][DATA_W]) begin
                        ent[i].r1_valid <= 1'b1;
                        ent[i].r1_data  <= wk1[i][DATA_W-1:0];
                    end
                    if (!ent[i].r2_valid && wk2[i][DATA_W]) begin
                        ent[i].r2_valid <= 1'b1;
                        ent[i].r2_data  <= wk2[i][DATA_W-1:0];
                    end
                end
            end
            if (accept) ent[free_idx] <= disp_ent;
        end
    end

    assign bus.rs_count       = cnt;
    assign bus.rs_is_full     = (cnt == CNT_W'(DEPTH));
    assign bus.issue_valid    = iss.valid;
    assign bus.issue_op       = iss.op;
    assign bus.issue_imm      = iss.imm;
    assign bus.issue_pc       = iss.pc;
    assign bus.issue_r1       = iss.r1;
    assign bus.issue_r2       = iss.r2;
    assign bus.issue_dest_tag = iss.dest_tag;
endmodule

// File: tb/tb_rs_station_param.sv
// Self-checking bench for rs_station_param: directed scenarios plus randomized traffic,
// compared against an age-ordered queue model of the station.
module tb_rs_station_param;
    localparam int unsigned SNAP_W = 1 + 6 + 4*32 + 4 + 5 + 1;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rs_station_param_if #(.DEPTH(16), .DATA_W(32), .TAG_W(4), .OP_W(6), .N_CDB(4)) bus ();

    rs_station_param #(.DEPTH(16), .DATA_W(32), .TAG_W(4), .OP_W(6), .N_CDB(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    // Reference model: queue in dispatch order, oldest at the front
    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm, pc;
        logic        r1v;
        logic [31:0] r1d;
        logic [3:0]  r1t;
        logic        r2v;
        logic [31:0] r2d;
        logic [3:0]  r2t;
        logic [3:0]  dest;
    } ment_t;

    ment_t       q[$];
    logic        m_iv;
    logic [5:0]  m_op;
    logic [31:0] m_imm, m_pc, m_r1, m_r2;
    logic [3:0]  m_dest;

    task automatic m_wipe();
        q.delete();
        m_iv = 1'b0; m_op = '0; m_imm = '0; m_pc = '0; m_r1 = '0; m_r2 = '0; m_dest = '0;
    endtask

    task automatic cdb_lookup(input logic [3:0] tag, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int b = 0; b < 4; b++) begin
            if (!hit && bus.cdb_valid[b] && bus.cdb_tag[b*4 +: 4] == tag) begin
                hit = 1'b1;
                d   = bus.cdb_data[b*32 +: 32];
            end
        end
    endtask

    task automatic model_step();
        int          sel;
        int          pre;
        logic        h;
        logic [31:0] d;
        ment_t       e;
        if (rst) begin m_wipe(); return; end
        if (!rdy) return;
        if (clear) begin m_wipe(); return; end
        pre = q.size();
        sel = -1;
        if (!m_iv || bus.issue_ready)
            foreach (q[i]) if (sel < 0 && q[i].r1v && q[i].r2v) sel = i;
        if (sel >= 0) begin
            m_iv = 1'b1; m_op = q[sel].op; m_imm = q[sel].imm; m_pc = q[sel].pc;
            m_r1 = q[sel].r1d; m_r2 = q[sel].r2d; m_dest = q[sel].dest;
        end else if (bus.issue_ready) begin
            m_iv = 1'b0;
        end
        foreach (q[i]) begin
            if (!q[i].r1v) begin cdb_lookup(q[i].r1t, h, d); if (h) begin q[i].r1v = 1'b1; q[i].r1d = d; end end
            if (!q[i].r2v) begin cdb_lookup(q[i].r2t, h, d); if (h) begin q[i].r2v = 1'b1; q[i].r2d = d; end end
        end
        if (sel >= 0) q.delete(sel);
        if (bus.dispatch_valid && pre < 16) begin
            e.op = bus.dispatch_op; e.imm = bus.dispatch_imm; e.pc = bus.dispatch_pc;
            e.r1t = bus.dispatch_r1_tag; e.r2t = bus.dispatch_r2_tag; e.dest = bus.dispatch_dest_tag;
            e.r1v = bus.dispatch_r1_valid; e.r1d = bus.dispatch_r1_data;
            e.r2v = bus.dispatch_r2_valid; e.r2d = bus.dispatch_r2_data;
            if (!e.r1v) begin cdb_lookup(e.r1t, h, d); if (h) begin e.r1v = 1'b1; e.r1d = d; end end
            if (!e.r2v) begin cdb_lookup(e.r2t, h, d); if (h) begin e.r2v = 1'b1; e.r2d = d; end end
            q.push_back(e);
        end
    endtask

    function automatic logic [SNAP_W-1:0] pack_snap(input logic iv, input logic [5:0] op,
            input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] r1,
            input logic [31:0] r2, input logic [3:0] dest, input logic [4:0] cnt, input logic full);
        if (!iv) begin op = '0; imm = '0; pc = '0; r1 = '0; r2 = '0; dest = '0; end
        return {iv, op, imm, pc, r1, r2, dest, cnt, full};
    endfunction

    function automatic logic [SNAP_W-1:0] dut_snap();
        return pack_snap(bus.issue_valid, bus.issue_op, bus.issue_imm, bus.issue_pc,
                         bus.issue_r1, bus.issue_r2, bus.issue_dest_tag, bus.rs_count, bus.rs_is_full);
    endfunction

    function automatic logic [SNAP_W-1:0] mdl_snap();
        return pack_snap(m_iv, m_op, m_imm, m_pc, m_r1, m_r2, m_dest, 5'(q.size()), q.size() == 16);
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = '0;
    endtask

    // Dispatch with a pc-derived payload; r2 always known
    task automatic set_disp(input logic [31:0] pc, input logic r1v, input logic [3:0] r1t, input logic [31:0] r1d);
        bus.dispatch_valid    = 1'b1;
        bus.dispatch_op       = pc[5:0];
        bus.dispatch_imm      = pc + 32'd1;
        bus.dispatch_pc       = pc;
        bus.dispatch_r1_valid = r1v;
        bus.dispatch_r1_tag   = r1t;
        bus.dispatch_r1_data  = r1d;
        bus.dispatch_r2_valid = 1'b1;
        bus.dispatch_r2_tag   = 4'd0;
        bus.dispatch_r2_data  = pc ^ 32'h5a5a_5a5a;
        bus.dispatch_dest_tag = pc[3:0];
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; bus.issue_ready = 1'b0;
        set_disp(32'h0, 1'b0, 4'd0, 32'h0);
        idle();
        bus.cdb_tag = '0; bus.cdb_data = '0;
        m_wipe();
        #1;
        checks++;
        if ({bus.issue_valid, bus.rs_count, bus.rs_is_full} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0", {bus.issue_valid, bus.rs_count, bus.rs_is_full});
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (dut_snap() !== mdl_snap()) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin set_disp(32'h300 + 32'(i), 1'b1, 4'd0, 32'(i)); step(); end
        idle();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.rs_count !== 5'd5) begin
            failures++; $display("FAIL midrst_pre got_iv=%b got_cnt=%0d exp_iv=1 exp_cnt=5", bus.issue_valid, bus.rs_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.issue_valid, bus.issue_pc, bus.issue_op, bus.rs_count, bus.rs_is_full} !== 45'b0) begin
            failures++; $display("FAIL midrst_async got_iv=%b pc=%h cnt=%0d exp=0", bus.issue_valid, bus.issue_pc, bus.rs_count);
        end
        step();
        rst = 1'b0;
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.issue_valid !== 1'b0 || bus.rs_count !== 5'd0) begin
                failures++; $display("FAIL midrst_after cyc=%0d got_iv=%b cnt=%0d exp_iv=0 cnt=0", i, bus.issue_valid, bus.rs_count);
            end
        end
    endtask

    task automatic test_full();
        do_clear();
        bus.issue_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin set_disp(32'h600 + 32'(i), 1'b0, 4'(i), 32'h0); step(); end
        checks++;
        if (bus.rs_is_full !== 1'b1 || bus.rs_count !== 5'd16 || bus.issue_valid !== 1'b0) begin
            failures++; $display("FAIL full_set got_full=%b cnt=%0d iv=%b exp 1/16/0", bus.rs_is_full, bus.rs_count, bus.issue_valid);
        end
        set_disp(32'h6ff, 1'b1, 4'd0, 32'h1);
        step();
        idle();
        checks++;
        if (bus.rs_count !== 5'd16 || dut_snap() !== mdl_snap()) begin
            failures++; $display("FAIL full_drop got_cnt=%0d exp=16", bus.rs_count);
        end
    endtask

    task automatic test_age_order();
        do_clear();
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin set_disp(32'h100 + 32'(i), 1'b0, 4'd9, 32'h0); step(); end
        set_disp(32'hA00, 1'b0, 4'd5, 32'h0);
        step();
        idle();
        bus.cdb_valid = 4'b0001; bus.cdb_tag = {4'd0, 4'd0, 4'd0, 4'd9}; bus.cdb_data = {96'h0, 32'h99};
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                failures++; $display("FAIL age_drain cyc=%0d got=%h exp=%h", i, dut_snap(), mdl_snap());
            end
        end
        set_disp(32'hB00, 1'b0, 4'd5, 32'h0);
        step();
        idle();
        bus.cdb_valid = 4'b0010; bus.cdb_tag = {4'd0, 4'd0, 4'd5, 4'd0}; bus.cdb_data = {64'h0, 32'h55, 32'h0};
        step();
        idle();
        step();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'hA00 || bus.issue_r1 !== 32'h55) begin
            failures++; $display("FAIL age_first got_pc=%h r1=%h exp_pc=a00 r1=55", bus.issue_pc, bus.issue_r1);
        end
        step();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'hB00 || bus.rs_count !== 5'd0) begin
            failures++; $display("FAIL age_second got_pc=%h cnt=%0d exp_pc=b00 cnt=0", bus.issue_pc, bus.rs_count);
        end
    endtask

    task automatic test_bypass();
        do_clear();
        bus.issue_ready = 1'b1;
        set_disp(32'h400, 1'b0, 4'd7, 32'h0);
        bus.cdb_valid = 4'b1100;
        bus.cdb_tag   = {4'd7, 4'd7, 4'd3, 4'd7};
        bus.cdb_data  = {32'hCAFEF00D, 32'hDEADBEEF, 32'h33333333, 32'h11111111};
        step();
        idle();
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.rs_count !== 5'd1) begin
            failures++; $display("FAIL bypass_e0 got_iv=%b cnt=%0d exp 0/1", bus.issue_valid, bus.rs_count);
        end
        step();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_r1 !== 32'hDEADBEEF || bus.issue_r2 !== (32'h400 ^ 32'h5a5a5a5a)) begin
            failures++; $display("FAIL bypass_data got_iv=%b r1=%h r2=%h exp r1=deadbeef", bus.issue_valid, bus.issue_r1, bus.issue_r2);
        end
    endtask

    task automatic test_stall();
        do_clear();
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin set_disp(32'h500 + 32'(i), 1'b1, 4'd0, 32'h50 + 32'(i)); step(); end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h500 || bus.issue_r1 !== 32'h50 || bus.rs_count !== 5'd2) begin
                failures++; $display("FAIL stall_hold cyc=%0d got_pc=%h cnt=%0d exp_pc=500 cnt=2", i, bus.issue_pc, bus.rs_count);
            end
        end
        bus.issue_ready = 1'b1;
        step();
        checks++;
        if (bus.issue_pc !== 32'h501 || bus.rs_count !== 5'd1) begin
            failures++; $display("FAIL stall_release got_pc=%h cnt=%0d exp_pc=501 cnt=1", bus.issue_pc, bus.rs_count);
        end
        step();
        checks++;
        if (bus.issue_pc !== 32'h502 || bus.issue_valid !== 1'b1 || bus.rs_count !== 5'd0) begin
            failures++; $display("FAIL stall_next got_pc=%h cnt=%0d exp_pc=502 cnt=0", bus.issue_pc, bus.rs_count);
        end
    endtask

    task automatic test_clear_rdy();
        do_clear();
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin set_disp(32'h700 + 32'(i), 1'b0, 4'd3, 32'h0); step(); end
        set_disp(32'h7ff, 1'b1, 4'd0, 32'h1);
        bus.cdb_valid = 4'b0001; bus.cdb_tag = {12'h0, 4'd3}; bus.cdb_data = {96'h0, 32'h77};
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle();
        checks++;
        if (bus.rs_count !== 5'd0 || bus.issue_valid !== 1'b0) begin
            failures++; $display("FAIL clear_flush got_cnt=%0d iv=%b exp 0/0", bus.rs_count, bus.issue_valid);
        end
        step();
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.rs_count !== 5'd0) begin
            failures++; $display("FAIL clear_after got_iv=%b cnt=%0d exp 0/0", bus.issue_valid, bus.rs_count);
        end
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin set_disp(32'h800 + 32'(i), 1'b1, 4'd0, 32'h8); step(); end
        set_disp(32'h8ff, 1'b1, 4'd0, 32'h9);
        bus.cdb_valid = 4'b1111;
        bus.issue_ready = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h800 || bus.rs_count !== 5'd1) begin
                failures++; $display("FAIL rdy_freeze cyc=%0d got_pc=%h cnt=%0d exp_pc=800 cnt=1", i, bus.issue_pc, bus.rs_count);
            end
        end
        rdy = 1'b1;
        idle();
        step();
        checks++;
        if (dut_snap() !== mdl_snap() || bus.issue_pc !== 32'h801) begin
            failures++; $display("FAIL rdy_resume got=%h exp=%h", dut_snap(), mdl_snap());
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int c = 0; c < 1500; c++) begin
            bus.dispatch_valid    = ($urandom_range(0, 9) < 6);
            bus.dispatch_op       = 6'($urandom);
            bus.dispatch_imm      = $urandom;
            bus.dispatch_pc       = $urandom;
            bus.dispatch_r1_valid = ($urandom_range(0, 2) == 0);
            bus.dispatch_r1_tag   = 4'($urandom_range(0, 7));
            bus.dispatch_r1_data  = $urandom;
            bus.dispatch_r2_valid = ($urandom_range(0, 2) == 0);
            bus.dispatch_r2_tag   = 4'($urandom_range(0, 7));
            bus.dispatch_r2_data  = $urandom;
            bus.dispatch_dest_tag = 4'($urandom);
            for (int b = 0; b < 4; b++) begin
                bus.cdb_valid[b]         = ($urandom_range(0, 3) == 0);
                bus.cdb_tag[b*4 +: 4]    = 4'($urandom_range(0, 7));
                bus.cdb_data[b*32 +: 32] = $urandom;
            end
            bus.issue_ready = ($urandom_range(0, 9) < 7);
            rdy             = ($urandom_range(0, 9) != 0);
            clear           = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_snap(), mdl_snap());
            end
        end
        rdy = 1'b1; clear = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_full();
        test_age_order();
        test_bypass();
        test_stall();
        test_clear_rdy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
